// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared types and helpers for the RC4 decrypted-message checker
package rc4_pkg;

   typedef enum logic [2:0] {
      CHK_IDLE,
      CHK_SET_ADDR,
      CHK_WAIT,
      CHK_SAMPLE,
      CHK_ADVANCE,
      CHK_DONE
   } chk_state_e;

   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CHAR_LO_A  = 8'h61;
   localparam logic [7:0] CHAR_LO_Z  = 8'h7A;

   function automatic logic is_msg_char(input logic [7:0] b);
      return (b == CHAR_SPACE) || ((b >= CHAR_LO_A) && (b <= CHAR_LO_Z));
   endfunction

endpackage

// File: rtl/msg_char_classifier.sv
// rtl/msg_char_classifier.sv - combinational legal-character flag for one message byte
module msg_char_classifier
   import rc4_pkg::*;
(
   input  logic [7:0] byte_i,
   output logic       legal_o
);

   assign legal_o = is_msg_char(byte_i);

endmodule

// File: rtl/decrypted_msg_checker.sv
// rtl/decrypted_msg_checker.sv - scans the decrypted RAM and reports whether every byte is a-z or space
// Optional CHECKER_EARLY_EXIT_EN stops the scan at the first illegal byte.
module decrypted_msg_checker
   import rc4_pkg::*;
#(
   parameter int MSG_LEN = 32,
   parameter int ADDR_W  = 8,
   parameter int RD_WAIT = 2
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   output logic [ADDR_W-1:0] dec_addr_o,
   input  logic [7:0]        dec_data_i,
   output logic              busy_o,
   output logic              finish_o,
   output logic              msg_valid_o,
   output logic [ADDR_W-1:0] bad_addr_o,
   output logic [ADDR_W-1:0] valid_count_o
);

   localparam logic [ADDR_W-1:0] LEN_A     = ADDR_W'(MSG_LEN);
   localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(MSG_LEN - 1);
   localparam int                CNT_W     = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
   localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);

   chk_state_e        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] bad_q, bad_d;
   logic [ADDR_W-1:0] vc_q, vc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              legal_q, legal_d;
   logic              mv_q, mv_d;
   logic              legal;
   logic              scan_end;

   msg_char_classifier u_classifier (
      .byte_i  (dec_data_i),
      .legal_o (legal)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= CHK_IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
         bad_q   <= LEN_A;
         vc_q    <= '0;
         cnt_q   <= '0;
         legal_q <= 1'b0;
         mv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         bad_q   <= bad_d;
         vc_q    <= vc_d;
         cnt_q   <= cnt_d;
         legal_q <= legal_d;
         mv_q    <= mv_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      bad_d    = bad_q;
      vc_d     = vc_q;
      cnt_d    = cnt_q;
      legal_d  = legal_q;
      mv_d     = mv_q;
      scan_end = 1'b0;
      case (state_q)
         CHK_IDLE: begin
            if (start_i) begin
               idx_d   = '0;
               mv_d    = 1'b0;
               bad_d   = LEN_A;
               vc_d    = '0;
               state_d = CHK_SET_ADDR;
            end
         end
         CHK_SET_ADDR: begin
            addr_d  = idx_q;
            cnt_d   = '0;
            state_d = (RD_WAIT == 0) ? CHK_SAMPLE : CHK_WAIT;
         end
         CHK_WAIT: begin
            if (cnt_q == WAIT_LAST) state_d = CHK_SAMPLE;
            else                    cnt_d   = cnt_q + 1'b1;
         end
         CHK_SAMPLE: begin
            legal_d = legal;
            state_d = CHK_ADVANCE;
         end
         CHK_ADVANCE: begin
            scan_end = (idx_q == LAST_A);
            if (legal_q)             vc_d  = vc_q + 1'b1;
            else if (bad_q == LEN_A) bad_d = idx_q;
`ifdef CHECKER_EARLY_EXIT_EN
            if (!legal_q) scan_end = 1'b1;
`else
`endif
            // msg_valid is settled on entry to DONE so it is valid alongside finish
            if (scan_end) begin
               mv_d    = (bad_d == LEN_A);
               state_d = CHK_DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = CHK_SET_ADDR;
            end
         end
         CHK_DONE: state_d = CHK_IDLE;
         default:  state_d = CHK_IDLE;
      endcase
   end

   assign dec_addr_o    = addr_q;
   assign busy_o        = (state_q != CHK_IDLE) && (state_q != CHK_DONE);
   assign finish_o      = (state_q == CHK_DONE);
   assign msg_valid_o   = mv_q;
   assign bad_addr_o    = bad_q;
   assign valid_count_o = vc_q;

endmodule

// File: tb/tb_decrypted_msg_checker.sv
// tb/tb_decrypted_msg_checker.sv - scoreboard bench for decrypted_msg_checker (RD_WAIT=2 and RD_WAIT=0 instances)
module tb_decrypted_msg_checker;

`ifdef CHECKER_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   typedef struct {
      int         lat;
      logic       mv;
      logic [7:0] bad;
      logic [7:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start2 = 1'b0, start0 = 1'b0;
   logic [7:0] addr2, addr0, data2, data0, bad2, bad0, cnt2, cnt0;
   logic       busy2, busy0, fin2, fin0, mv2, mv0;
   logic [7:0] mem [256];
   logic [7:0] last2 = '0, last0 = '0;
   int         age2 = 0, age0 = 0;
   int         fin_cnt2 = 0, fin_cnt0 = 0;
   int         vectors = 0, miscompares = 0;
   exp_t       sb[$];

   always #5 clk = ~clk;

   decrypted_msg_checker #(.MSG_LEN(32), .ADDR_W(8), .RD_WAIT(2)) dut (
      .clk_i(clk), .reset_i(reset), .start_i(start2), .dec_addr_o(addr2), .dec_data_i(data2),
      .busy_o(busy2), .finish_o(fin2), .msg_valid_o(mv2), .bad_addr_o(bad2), .valid_count_o(cnt2));

   decrypted_msg_checker #(.MSG_LEN(32), .ADDR_W(8), .RD_WAIT(0)) dut0 (
      .clk_i(clk), .reset_i(reset), .start_i(start0), .dec_addr_o(addr0), .dec_data_i(data0),
      .busy_o(busy0), .finish_o(fin0), .msg_valid_o(mv0), .bad_addr_o(bad0), .valid_count_o(cnt0));

   // RAM model: data is only valid once the address has been stable for RD_WAIT edges
   always @(negedge clk) begin
      if (addr2 !== last2) begin last2 <= addr2; age2 <= 0; end
      else if (age2 < 1000) age2 <= age2 + 1;
      if (addr0 !== last0) begin last0 <= addr0; age0 <= 0; end
      else if (age0 < 1000) age0 <= age0 + 1;
      if (fin2 === 1'b1) fin_cnt2 <= fin_cnt2 + 1;
      if (fin0 === 1'b1) fin_cnt0 <= fin_cnt0 + 1;
   end

   always_comb begin
      data2 = (age2 >= 2) ? mem[addr2] : 8'hFF;
      data0 = mem[addr0];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic cur_fin(input int sel);
      return (sel != 0) ? fin0 : fin2;
   endfunction

   function automatic logic cur_busy(input int sel);
      return (sel != 0) ? busy0 : busy2;
   endfunction

   task automatic set_start(input int sel, input logic v);
      if (sel != 0) start0 = v;
      else          start2 = v;
   endtask

   task automatic fill_legal();
      for (int i = 0; i < 256; i++)
         mem[i] = (i % 5 == 4) ? 8'h20 : 8'(8'h61 + (i % 26));
   endtask

   task automatic push_exp(input int lat, input logic mv, input logic [7:0] bad, input logic [7:0] cnt);
      exp_t e;
      e.lat = lat; e.mv = mv; e.bad = bad; e.cnt = cnt;
      sb.push_back(e);
   endtask

   // Called right after the edge that accepted start; n counts edges after it
   task automatic wait_finish(input int sel, input bit hold, input int pulse_at);
      int   n = 0;
      bit   got = 0;
      exp_t e;
      while (n < 1000 && !got) begin
         if (n == pulse_at) set_start(sel, 1'b1);
         else if (n == pulse_at + 1 && !hold) set_start(sel, 1'b0);
         tick();
         n++;
         if (cur_fin(sel) === 1'b1) got = 1;
      end
      check("finish_seen", 32'(got), 32'd1);
      e = sb.pop_front();
      check("latency", 32'(n + 1), 32'(e.lat));
      check("msg_valid", 32'((sel != 0) ? mv0 : mv2), 32'(e.mv));
      check("bad_addr", 32'((sel != 0) ? bad0 : bad2), 32'(e.bad));
      check("valid_count", 32'((sel != 0) ? cnt0 : cnt2), 32'(e.cnt));
   endtask

   task automatic run_scan(input int sel, input int lat, input logic mv, input logic [7:0] bad,
                           input logic [7:0] cnt, input bit hold, input int pulse_at);
      push_exp(lat, mv, bad, cnt);
      set_start(sel, 1'b1);
      tick();
      check("accept_busy", 32'(cur_busy(sel)), 32'd1);
      if (!hold) set_start(sel, 1'b0);
      wait_finish(sel, hold, pulse_at);
   endtask

   initial begin
      int fc;
      fill_legal();
      reset = 1'b1;
      repeat (3) tick();
      check("rst_busy", 32'(busy2), 32'd0);
      check("rst_finish", 32'(fin2), 32'd0);
      check("rst_msg_valid", 32'(mv2), 32'd0);
      check("rst_dec_addr", 32'(addr2), 32'd0);
      check("rst_bad_addr", 32'(bad2), 32'd32);
      check("rst_valid_count", 32'(cnt2), 32'd0);
      reset = 1'b0;
      tick();

      // all legal
      fc = fin_cnt2;
      run_scan(0, 161, 1'b1, 8'd32, 8'd32, 1'b0, -1);
      tick();
      check("addr_hold_idle", 32'(addr2), 32'd31);
      check("one_finish_t1", 32'(fin_cnt2 - fc), 32'd1);

      // single uppercase byte at index 5
      mem[5] = 8'h41;
      run_scan(0, EE ? 31 : 161, 1'b0, 8'd5, EE ? 8'd5 : 8'd31, 1'b0, -1);
      tick();

      // boundary characters
      fill_legal();
      mem[0] = 8'h60; mem[1] = 8'h7B; mem[2] = 8'h1F; mem[3] = 8'h7A; mem[4] = 8'h20;
      run_scan(0, EE ? 6 : 161, 1'b0, 8'd0, EE ? 8'd0 : 8'd29, 1'b0, -1);
      tick();

      // start held through a scan, back-to-back restart, mid-scan pulse ignored
      fill_legal();
      mem[5] = 8'h41;
      fc = fin_cnt2;
      run_scan(0, EE ? 31 : 161, 1'b0, 8'd5, EE ? 8'd5 : 8'd31, 1'b1, -1);
      tick();
      check("restart_idle_busy", 32'(busy2), 32'd0);
      check("restart_results_held", 32'(bad2), 32'd5);
      tick();
      check("restart_busy", 32'(busy2), 32'd1);
      check("restart_bad_cleared", 32'(bad2), 32'd32);
      check("restart_cnt_cleared", 32'(cnt2), 32'd0);
      start2 = 1'b0;
      push_exp(EE ? 31 : 161, 1'b0, 8'd5, EE ? 8'd5 : 8'd31);
      wait_finish(0, 1'b0, EE ? 10 : 40);
      repeat (20) tick();
      check("two_finishes", 32'(fin_cnt2 - fc), 32'd2);
      check("idle_after_pair", 32'(busy2), 32'd0);

      // reset mid-scan
      fill_legal();
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      repeat (49) tick();
      check("pre_reset_busy", 32'(busy2), 32'd1);
      fc = fin_cnt2;
      reset = 1'b1;
      tick();
      check("abort_busy", 32'(busy2), 32'd0);
      check("abort_dec_addr", 32'(addr2), 32'd0);
      check("abort_bad_addr", 32'(bad2), 32'd32);
      check("abort_valid_count", 32'(cnt2), 32'd0);
      check("abort_finish", 32'(fin2), 32'd0);
      reset = 1'b0;
      repeat (5) tick();
      check("abort_no_finish", 32'(fin_cnt2 - fc), 32'd0);
      run_scan(0, 161, 1'b1, 8'd32, 8'd32, 1'b0, -1);
      tick();

      // zero-latency RAM instance
      run_scan(1, 97, 1'b1, 8'd32, 8'd32, 1'b0, -1);
      mem[7] = 8'h7B;
      tick();
      run_scan(1, EE ? 25 : 97, 1'b0, 8'd7, EE ? 8'd7 : 8'd31, 1'b0, -1);
      tick();

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
